// File: rtl/output_drainer_if.sv
// Handshake bundle linking the accumulator source, the output drainer and the downstream word sink.
// The master modport is the environment side; the slave modport is the drainer.
interface output_drainer_if #(
  parameter int PSUM_WIDTH   = 20,
  parameter int M            = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int STREAM_WIDTH = 4
);
  logic                                start;
  logic [15:0]                         cfg_total_vec;
  logic [4:0]                          cfg_shift;
  logic                                cfg_relu;
  logic                                in_valid;
  logic                                in_ready;
  logic signed [PSUM_WIDTH-1:0]        in_data [0:M-1];
  logic [DATA_WIDTH*STREAM_WIDTH-1:0]  out_data;
  logic                                out_valid;
  logic                                out_ready;
  logic                                out_last;
  logic                                busy;
  logic                                done;

  modport master (
    output start, cfg_total_vec, cfg_shift, cfg_relu, in_valid, in_data, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    input  start, cfg_total_vec, cfg_shift, cfg_relu, in_valid, in_data, out_ready,
    output in_ready, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/output_drainer.sv
// Requantises accumulator vectors into a two-entry FIFO and streams them out as packed words,
// STREAM_WIDTH lanes per word, for a job of cfg_total_vec vectors.
module output_drainer #(
  parameter int PSUM_WIDTH   = 20,
  parameter int M            = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int STREAM_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output_drainer_if.slave  bus
);
  localparam int W      = M / STREAM_WIDTH;
  localparam int WIDX_W = (W > 1) ? $clog2(W) : 1;
  localparam int LANE_W = (M > 1) ? $clog2(M) : 1;
  localparam int WORD_W = DATA_WIDTH * STREAM_WIDTH;
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(W - 1);
  localparam logic signed [PSUM_WIDTH-1:0] SAT_MAX = PSUM_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PSUM_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             total_q, total_d;
  logic [4:0]              shift_q, shift_d;
  logic                    relu_q, relu_d;
  logic [15:0]             acc_cnt_q, acc_cnt_d;
  logic [15:0]             emit_cnt_q, emit_cnt_d;
  logic [WIDX_W-1:0]       word_idx_q, word_idx_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;
  logic [DATA_WIDTH-1:0]   buf_q [0:1][0:M-1];
  logic [DATA_WIDTH-1:0]   buf_d [0:1][0:M-1];
  logic [DATA_WIDTH-1:0]   cap   [0:M-1];

  logic                    in_ready;
  logic                    out_valid;
  logic                    out_last;
  logic                    push;
  logic                    pop_word;
  logic                    pop_vec;
  logic [WORD_W-1:0]       word;

  // Floor shift, optional ReLU, then saturate to the signed output range.
  function automatic logic [DATA_WIDTH-1:0] requant(input logic signed [PSUM_WIDTH-1:0] v,
                                                    input logic [4:0] sh,
                                                    input logic relu);
    logic signed [PSUM_WIDTH-1:0] s;
    s = v >>> sh;
    if (relu && s[PSUM_WIDTH-1]) s = '0;
    if (s > SAT_MAX)      s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
    return s[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < M; i++) cap[i] = requant(bus.in_data[i], shift_q, relu_q);
  end

  assign in_ready  = (state_q == RUN) && (count_q != 2'd2) && (acc_cnt_q < total_q);
  assign out_valid = (state_q == RUN) && (count_q != 2'd0);
  assign out_last  = out_valid && (word_idx_q == LAST_IDX) && (emit_cnt_q == total_q - 16'd1);
  assign push      = bus.in_valid && in_ready;
  assign pop_word  = out_valid && bus.out_ready;
  assign pop_vec   = pop_word && (word_idx_q == LAST_IDX);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    acc_cnt_d  = acc_cnt_q;
    emit_cnt_d = emit_cnt_q;
    word_idx_d = word_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    buf_d      = buf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          total_d    = bus.cfg_total_vec;
          shift_d    = bus.cfg_shift;
          relu_d     = bus.cfg_relu;
          acc_cnt_d  = '0;
          emit_cnt_d = '0;
          word_idx_d = '0;
          wr_ptr_d   = 1'b0;
          rd_ptr_d   = 1'b0;
          count_d    = '0;
          state_d    = (bus.cfg_total_vec == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (push) begin
          buf_d[wr_ptr_q] = cap;
          wr_ptr_d        = ~wr_ptr_q;
          acc_cnt_d       = acc_cnt_q + 16'd1;
        end
        if (pop_word) word_idx_d = pop_vec ? '0 : word_idx_q + WIDX_W'(1);
        if (pop_vec) begin
          rd_ptr_d   = ~rd_ptr_q;
          emit_cnt_d = emit_cnt_q + 16'd1;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop_vec};
        if (pop_word && out_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane k*S+u of the head entry lands u slots below the top of the word.
  always_comb begin
    word = '0;
    for (int u = 0; u < STREAM_WIDTH; u++) begin
      word[WORD_W-1-u*DATA_WIDTH -: DATA_WIDTH] =
        buf_q[rd_ptr_q][LANE_W'(int'(word_idx_q) * STREAM_WIDTH + u)];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      total_q    <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      acc_cnt_q  <= '0;
      emit_cnt_q <= '0;
      word_idx_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      acc_cnt_q  <= acc_cnt_d;
      emit_cnt_q <= emit_cnt_d;
      word_idx_q <= word_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: buffer storage is not reset; count_q marks entries invalid and out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_data  = out_valid ? word : '0;
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_output_drainer.sv
// Directed bench for output_drainer: reset, basic job, requantisation, backpressure,
// simultaneous push/pop, zero-length job and mid-job reset.
module tb_output_drainer;
  localparam int PSUM_WIDTH   = 20;
  localparam int M            = 8;
  localparam int DATA_WIDTH   = 8;
  localparam int STREAM_WIDTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_drainer_if #(.PSUM_WIDTH(PSUM_WIDTH), .M(M), .DATA_WIDTH(DATA_WIDTH),
                      .STREAM_WIDTH(STREAM_WIDTH)) bus ();

  output_drainer #(.PSUM_WIDTH(PSUM_WIDTH), .M(M), .DATA_WIDTH(DATA_WIDTH),
                   .STREAM_WIDTH(STREAM_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] obs_word [32];
  logic        obs_last [32];
  int          obs_n, done_at, last_at, acc_n;
  logic        inrdy_seen, ovalid_seen;

  // Lane bytes of vector v are v*16+1+lane, so word k of vector v is predictable.
  function automatic logic [31:0] exp_word(input int v, input int k);
    logic [31:0] w;
    w = '0;
    for (int u = 0; u < 4; u++) w[31-8*u -: 8] = 8'(v * 16 + 1 + 4 * k + u);
    return w;
  endfunction

  task automatic set_lanes(input int base);
    for (int i = 0; i < M; i++) bus.in_data[i] = PSUM_WIDTH'(base + i);
  endtask

  task automatic drive_idle();
    bus.start         = 1'b0;
    bus.cfg_total_vec = '0;
    bus.cfg_shift     = '0;
    bus.cfg_relu      = 1'b0;
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
    set_lanes(0);
  endtask

  // Starts a job with in_valid and out_ready held high and records every emitted word.
  task automatic run_job(input logic [15:0] total, input logic [4:0] shift,
                         input logic relu, input int budget);
    obs_n = 0; done_at = -1; last_at = -1; acc_n = 0;
    inrdy_seen = 1'b0; ovalid_seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.cfg_total_vec = total; bus.cfg_shift = shift; bus.cfg_relu = relu;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (bus.done) begin done_at = c; break; end
      if (bus.in_ready) begin inrdy_seen = 1'b1; acc_n++; end
      if (bus.out_valid) ovalid_seen = 1'b1;
      if (bus.out_valid && bus.out_ready && obs_n < 32) begin
        obs_word[obs_n] = bus.out_data;
        obs_last[obs_n] = bus.out_last;
        last_at = c;
        obs_n++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done});
    end
    checks++;
    if (bus.out_data !== 32'h0) begin
      failures++; $display("FAIL reset_out_data: got %h expected 00000000", bus.out_data);
    end
    rst = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.busy} !== 2'b00) begin
      failures++; $display("FAIL reset_needs_start: got %b expected 00", {bus.in_ready, bus.busy});
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] exp;
    set_lanes(1);
    run_job(16'd2, 5'd0, 1'b0, 50);
    checks++;
    if (obs_n !== 4) begin failures++; $display("FAIL basic_count: got %0d expected 4", obs_n); end
    for (int k = 0; k < 4 && k < obs_n; k++) begin
      exp = (k % 2 == 0) ? 32'h01020304 : 32'h05060708;
      checks++;
      if (obs_word[k] !== exp) begin
        failures++; $display("FAIL basic_word%0d: got %h expected %h", k, obs_word[k], exp);
      end
      checks++;
      if (obs_last[k] !== (k == 3)) begin
        failures++; $display("FAIL basic_last%0d: got %b expected %b", k, obs_last[k], k == 3);
      end
    end
    checks++;
    if (done_at < 0 || done_at !== last_at + 1) begin
      failures++; $display("FAIL basic_done_timing: got %0d expected %0d", done_at, last_at + 1);
    end
    checks++;
    if (acc_n !== 2) begin failures++; $display("FAIL basic_accepts: got %0d expected 2", acc_n); end
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_in_done: got %b expected 1", bus.busy); end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      failures++; $display("FAIL basic_done_pulse: got %b expected 00", {bus.done, bus.busy});
    end
  endtask

  task automatic test_requant();
    logic [31:0] exp0 [2];
    logic [31:0] exp1 [2];
    bus.in_data[0] = 20'sd1000;  bus.in_data[1] = -20'sd1000;
    bus.in_data[2] = 20'sd300;   bus.in_data[3] = -20'sd5;
    bus.in_data[4] = 20'sd0;     bus.in_data[5] = 20'sd7;
    bus.in_data[6] = -20'sd1;    bus.in_data[7] = 20'sd512;
    exp0[0] = 32'h7F804BFE; exp1[0] = 32'h0001FF7F;
    exp0[1] = 32'h7F004B00; exp1[1] = 32'h0001007F;
    for (int r = 0; r < 2; r++) begin
      run_job(16'd1, 5'd2, r[0], 40);
      checks++;
      if (obs_n !== 2) begin
        failures++; $display("FAIL requant_count relu=%0d: got %0d expected 2", r, obs_n);
      end else begin
        checks++;
        if (obs_word[0] !== exp0[r]) begin
          failures++; $display("FAIL requant_w0 relu=%0d: got %h expected %h", r, obs_word[0], exp0[r]);
        end
        checks++;
        if (obs_word[1] !== exp1[r]) begin
          failures++; $display("FAIL requant_w1 relu=%0d: got %h expected %h", r, obs_word[1], exp1[r]);
        end
        checks++;
        if ({obs_last[0], obs_last[1]} !== 2'b01) begin
          failures++; $display("FAIL requant_last relu=%0d: got %b expected 01", r, {obs_last[0], obs_last[1]});
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    logic        have;
    int          unstable;
    bus.out_ready = 1'b0;
    set_lanes(1);
    @(negedge clk);
    bus.start = 1'b1; bus.cfg_total_vec = 16'd3; bus.cfg_shift = 5'd0; bus.cfg_relu = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    acc_n = 0; have = 1'b0; unstable = 0; held = '0;
    // Hold out_ready low; a start pulse mid-run with total=0 must be ignored.
    for (int c = 0; c < 10; c++) begin
      set_lanes(acc_n * 16 + 1);
      bus.start = (c == 4);
      if (c == 4) begin bus.cfg_total_vec = 16'd0; bus.cfg_shift = 5'd3; end
      if (bus.in_ready) acc_n++;
      if (bus.out_valid) begin
        if (!have) begin held = bus.out_data; have = 1'b1; end
        else if (bus.out_data !== held || bus.out_last !== 1'b0) unstable++;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++;
    if (acc_n !== 2) begin failures++; $display("FAIL bp_accepts: got %0d expected 2", acc_n); end
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
      failures++; $display("FAIL bp_ready_valid: got %b expected 01", {bus.in_ready, bus.out_valid});
    end
    checks++;
    if (unstable !== 0 || held !== exp_word(0, 0)) begin
      failures++; $display("FAIL bp_hold: got %h (%0d changes) expected %h", held, unstable, exp_word(0, 0));
    end
    bus.out_ready = 1'b1;
    obs_n = 0; done_at = -1;
    for (int c = 0; c < 40; c++) begin
      set_lanes(acc_n * 16 + 1);
      if (bus.done) begin done_at = c; break; end
      if (bus.in_ready) acc_n++;
      if (bus.out_valid && obs_n < 32) begin
        obs_word[obs_n] = bus.out_data; obs_last[obs_n] = bus.out_last; obs_n++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (obs_n !== 6 || done_at < 0) begin
      failures++; $display("FAIL bp_drain: got %0d words done_at=%0d expected 6 words and done", obs_n, done_at);
    end
    for (int k = 0; k < 6 && k < obs_n; k++) begin
      checks++;
      if (obs_word[k] !== exp_word(k / 2, k % 2) || obs_last[k] !== (k == 5)) begin
        failures++;
        $display("FAIL bp_word%0d: got %h last=%b expected %h last=%b", k, obs_word[k], obs_last[k],
                 exp_word(k / 2, k % 2), k == 5);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    bus.out_ready = 1'b1;
    set_lanes(1);
    @(negedge clk);
    bus.start = 1'b1; bus.cfg_total_vec = 16'd3; bus.cfg_shift = 5'd0; bus.cfg_relu = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL sim_first_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_word(0, 0)) begin
      failures++; $display("FAIL sim_first_latency: got valid=%b %h expected valid=1 %h",
                           bus.out_valid, bus.out_data, exp_word(0, 0));
    end
    @(negedge clk);
    set_lanes(17);
    bus.in_valid = 1'b1;
    checks++;
    if (bus.out_data !== exp_word(0, 1) || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL sim_pop_cycle: got %h ready=%b expected %h ready=1",
                           bus.out_data, bus.in_ready, exp_word(0, 1));
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b11 || bus.out_data !== exp_word(1, 0)) begin
      failures++; $display("FAIL sim_occupancy_one: got valid/ready=%b %h expected 11 %h",
                           {bus.out_valid, bus.in_ready}, bus.out_data, exp_word(1, 0));
    end
    set_lanes(33);
    obs_n = 0; done_at = -1;
    for (int c = 0; c < 30; c++) begin
      if (bus.done) begin done_at = c; break; end
      if (bus.out_valid && obs_n < 32) begin
        obs_word[obs_n] = bus.out_data; obs_last[obs_n] = bus.out_last; obs_n++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (obs_n !== 4 || done_at < 0) begin
      failures++; $display("FAIL sim_drain: got %0d words done_at=%0d expected 4 words and done", obs_n, done_at);
    end
    for (int k = 0; k < 4 && k < obs_n; k++) begin
      checks++;
      if (obs_word[k] !== exp_word(1 + k / 2, k % 2) || obs_last[k] !== (k == 3)) begin
        failures++;
        $display("FAIL sim_word%0d: got %h last=%b expected %h last=%b", k, obs_word[k], obs_last[k],
                 exp_word(1 + k / 2, k % 2), k == 3);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    run_job(16'd0, 5'd0, 1'b0, 10);
    checks++;
    if (done_at !== 0) begin failures++; $display("FAIL zero_done: got %0d expected 0", done_at); end
    checks++;
    if ({bus.in_ready, bus.out_valid, inrdy_seen, ovalid_seen} !== 4'b0 || obs_n !== 0) begin
      failures++; $display("FAIL zero_no_traffic: got %b words=%0d expected 0000 words=0",
                           {bus.in_ready, bus.out_valid, inrdy_seen, ovalid_seen}, obs_n);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic found;
    int   bad;
    set_lanes(1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.cfg_total_vec = 16'd2; bus.cfg_shift = 5'd0; bus.cfg_relu = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mreset_first_word: got none expected a word"); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done} !== 5'b0 || bus.out_data !== 32'h0) begin
      failures++; $display("FAIL mreset_immediate: got %b %h expected 00000 00000000",
                           {bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done}, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.in_ready || bus.out_valid || bus.done || bus.busy) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL mreset_idle_after: got %0d active cycles expected 0", bad); end
    bus.in_valid = 1'b0;
    run_job(16'd2, 5'd0, 1'b0, 50);
    checks++;
    if (obs_n !== 4 || obs_word[0] !== 32'h01020304 || done_at < 0) begin
      failures++; $display("FAIL mreset_rerun: got %0d words first=%h done_at=%0d expected 4 01020304 done",
                           obs_n, obs_word[0], done_at);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_requant();
    test_backpressure();
    test_simultaneous();
    test_zero_len();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
